// File: rtl/sparc_sscan_unload.sv
// rtl/sparc_sscan_unload.sv - shadow-scan unload controller: snap, shift, deserialize, hand off to host
module sparc_sscan_unload #(
  parameter int WIDTH     = 94,
  parameter int DIV       = 4,
  parameter int SNAP_WAIT = 2,
  parameter int CW        = 7
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             req,
  input  logic             abort,
  input  logic             sparc_sscan_so,
  output logic             sscan_snap,
  output logic             sscan_se,
  output logic             sscan_shift,
  output logic             busy,
  output logic [WIDTH-1:0] data_out,
  output logic             data_vld,
  input  logic             data_ack
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WW = (SNAP_WAIT > 1) ? $clog2(SNAP_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNAP  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;

  logic strobe, last_bit, wait_done;

  assign strobe    = (state == S_SHIFT) && (div_cnt == DW'(DIV - 1));
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign wait_done = (wait_cnt == WW'(SNAP_WAIT - 1));

  // Outputs are pure decodes of flops, so there is no input-to-output path.
  assign sscan_snap  = (state == S_SNAP);
  assign sscan_se    = (state == S_SHIFT);
  assign sscan_shift = strobe;
  assign busy        = (state != S_IDLE);
  assign data_vld    = (state == S_HOLD);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req) state_nxt = S_SNAP;
      S_SNAP:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_done) state_nxt = S_SHIFT;
      S_SHIFT: if (strobe && last_bit) state_nxt = S_HOLD;
      S_HOLD:  if (data_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        div_cnt  <= '0;
        wait_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        wait_cnt <= (state == S_WAIT && !wait_done) ? wait_cnt + WW'(1) : '0;
        if (state == S_SHIFT) begin
          div_cnt <= strobe ? '0 : div_cnt + DW'(1);
          if (strobe) begin
            bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
            shift_reg <= {shift_reg[WIDTH-2:0], sparc_sscan_so};
            // Publish only a complete word so an aborted unload never disturbs data_out.
            if (last_bit) data_out <= {shift_reg[WIDTH-2:0], sparc_sscan_so};
          end
        end else begin
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparc_sscan_unload.sv
// tb/tb_sparc_sscan_unload.sv - directed self-checking bench for sparc_sscan_unload
module tb_sparc_sscan_unload;

  logic       rclk = 1'b0;
  logic       arst_l;
  logic       req, abort, so, ack;
  logic       snap, se, shift, busy, vld;
  logic [7:0] dout;

  logic        d_req, d_abort, d_so, d_ack;
  logic        d_snap, d_se, d_shift, d_busy, d_vld;
  logic [93:0] d_dout;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  sparc_sscan_unload #(.WIDTH(8), .DIV(2), .SNAP_WAIT(2), .CW(4)) dut (
    .rclk(rclk), .arst_l(arst_l), .req(req), .abort(abort), .sparc_sscan_so(so),
    .sscan_snap(snap), .sscan_se(se), .sscan_shift(shift), .busy(busy),
    .data_out(dout), .data_vld(vld), .data_ack(ack)
  );

  sparc_sscan_unload dut_def (
    .rclk(rclk), .arst_l(arst_l), .req(d_req), .abort(d_abort), .sparc_sscan_so(d_so),
    .sscan_snap(d_snap), .sscan_se(d_se), .sscan_shift(d_shift), .busy(d_busy),
    .data_out(d_dout), .data_vld(d_vld), .data_ack(d_ack)
  );

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Drives so on each strobe (MSB first) until data_vld or the cycle budget runs out.
  task automatic feed(input logic [7:0] pat, output bit ok);
    int idx = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (vld) begin
        ok = 1'b1;
        break;
      end
      if (shift && idx < 8) begin
        so = pat[7-idx];
        idx++;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({snap, se, shift, busy, vld} !== 5'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got ctl=%b dout=%h, want ctl=00000 dout=00", {snap, se, shift, busy, vld}, dout);
    end
    checks++;
    if ({d_snap, d_se, d_shift, d_busy, d_vld} !== 5'b0 || d_dout !== 94'd0) begin
      errors++;
      $display("FAIL reset_outputs_def: got ctl=%b, want 00000", {d_snap, d_se, d_shift, d_busy, d_vld});
    end
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'b1011_0010;
    logic [3:0] exp;
    int idx = 0;
    req = 1'b1;
    tick();
    req = 1'b0;
    checks++;
    if (snap !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_snap: got snap=%b busy=%b, want 1 1", snap, busy);
    end
    for (int c = 1; c <= 19; c++) begin
      if (shift && idx < 8) begin
        so = pat[7-idx];
        idx++;
      end
      tick();
      exp = {1'b0, (c >= 3 && c <= 18), (c >= 4 && c <= 18 && c % 2 == 0), (c == 19)};
      checks++;
      if ({snap, se, shift, vld} !== exp) begin
        errors++;
        $display("FAIL basic_timing cycle k+%0d: got snap/se/shift/vld=%b, want %b", c, {snap, se, shift, vld}, exp);
      end
    end
    checks++;
    if (dout !== 8'hB2) begin
      errors++;
      $display("FAIL basic_data: got %h, want b2", dout);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: got vld=%b busy=%b, want 0 0", vld, busy);
    end
  endtask

  task automatic test_hold_ack();
    bit ok;
    bit stable = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    feed(8'hB2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_vld_timeout: got vld=%b, want 1", vld);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      if (vld !== 1'b1 || dout !== 8'hB2 || se !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL hold_stable: got vld=%b dout=%h se=%b, want 1 b2 0", vld, dout, se);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if ({snap, se, busy, vld} !== 4'b0 || dout !== 8'hB2) begin
      errors++;
      $display("FAIL ack_in_idle: got snap/se/busy/vld=%b dout=%h, want 0000 b2", {snap, se, busy, vld}, dout);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    req = 1'b1;
    tick();
    feed(8'hB2, ok);
    checks++;
    if (!ok || dout !== 8'hB2) begin
      errors++;
      $display("FAIL b2b_first: got ok=%0d dout=%h, want 1 b2", ok, dout);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy=%b vld=%b, want 0 0", busy, vld);
    end
    tick();
    req = 1'b0;
    checks++;
    if (snap !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_snap: got snap=%b, want 1", snap);
    end
    feed(8'hFF, ok);
    checks++;
    if (!ok || dout !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_second: got ok=%0d dout=%h, want 1 ff", ok, dout);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_abort();
    int strobes = 0;
    bit never_vld = 1'b1;
    req = 1'b1;
    tick();
    req = 1'b0;
    so = 1'b0;
    for (int i = 0; i < 40 && strobes < 3; i++) begin
      if (shift) strobes++;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, se, shift, snap, vld} !== 5'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy/se/shift/snap/vld=%b after %0d strobes, want 00000", {busy, se, shift, snap, vld}, strobes);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (vld !== 1'b0) never_vld = 1'b0;
    end
    checks++;
    if (!never_vld || dout !== 8'hFF) begin
      errors++;
      $display("FAIL abort_data: got vld_seen=%0d dout=%h, want 0 ff", !never_vld, dout);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (se !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_shift: got se=%b, want 1", se);
    end
    #2 arst_l = 1'b0;
    #1;
    checks++;
    if ({snap, se, shift, busy, vld} !== 5'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: got ctl=%b dout=%h, want 00000 00", {snap, se, shift, busy, vld}, dout);
    end
    #12 arst_l = 1'b1;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    feed(8'h5A, ok);
    checks++;
    if (!ok || dout !== 8'h5A) begin
      errors++;
      $display("FAIL rst_restart: got ok=%0d dout=%h, want 1 5a", ok, dout);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_default_walk();
    int pos[3] = '{0, 50, 93};
    int cyc, idx;
    logic [93:0] exp;
    for (int t = 0; t < 3; t++) begin
      d_req = 1'b1;
      tick();
      d_req = 1'b0;
      cyc = 0;
      idx = 0;
      for (int i = 0; i < 500; i++) begin
        if (d_vld) break;
        d_so = 1'b0;
        if (d_shift) begin
          d_so = (idx == pos[t]);
          idx++;
        end
        tick();
        cyc++;
      end
      exp = 94'd1 << (93 - pos[t]);
      checks++;
      if (cyc !== 379) begin
        errors++;
        $display("FAIL def_latency walk %0d: got %0d cycles, want 379", pos[t], cyc);
      end
      checks++;
      if (d_dout !== exp || d_vld !== 1'b1) begin
        errors++;
        $display("FAIL def_data walk %0d: got %h vld=%b, want %h 1", pos[t], d_dout, d_vld, exp);
      end
      d_ack = 1'b1;
      tick();
      d_ack = 1'b0;
    end
  endtask

  initial begin
    arst_l = 1'b0;
    {req, abort, so, ack} = 4'b0;
    {d_req, d_abort, d_so, d_ack} = 4'b0;
    #22;
    test_reset();
    arst_l = 1'b1;
    tick();
    test_basic();
    test_hold_ack();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    test_default_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
